vxe_axi4slv_burst_biu: RTL and testbench

AXI4 slave bus interface unit with full burst support (FIXED, INCR, WRAP), replacing the single-beat slave BIU in front of VxEngine register and memory targets. It converts each AXI4 burst into a sequence of single-beat BIU accesses and generates per-beat addresses. It returns one merged write response per burst and per-beat read data with RLAST. Read and write paths are independent; each path holds one burst in flight.

---
 rtl/vxe_axi4slv_burst_biu.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_vxe_axi4slv_burst_biu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vxe_axi4slv_burst_biu.sv
`default_nettype none
// vxe_axi4slv_burst_biu: splits AXI4 FIXED/INCR/WRAP bursts into single-beat BIU accesses.
// Optional WRAP address support is enabled by defining VXE_AXI4SLV_BIU_WRAP_EN.
module vxe_axi4slv_burst_biu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                    S_AXI4_ACLK,
    input  logic                    S_AXI4_ARESETn,
    input  logic [ID_WIDTH-1:0]     S_AXI4_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI4_AWADDR,
    input  logic [7:0]              S_AXI4_AWLEN,
    input  logic [2:0]              S_AXI4_AWSIZE,
    input  logic [1:0]              S_AXI4_AWBURST,
    input  logic                    S_AXI4_AWLOCK,
    input  logic [3:0]              S_AXI4_AWCACHE,
    input  logic [2:0]              S_AXI4_AWPROT,
    input  logic                    S_AXI4_AWVALID,
    output logic                    S_AXI4_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI4_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI4_WSTRB,
    input  logic                    S_AXI4_WLAST,
    input  logic                    S_AXI4_WVALID,
    output logic                    S_AXI4_WREADY,
    output logic [ID_WIDTH-1:0]     S_AXI4_BID,
    output logic [1:0]              S_AXI4_BRESP,
    output logic                    S_AXI4_BVALID,
    input  logic                    S_AXI4_BREADY,
    input  logic [ID_WIDTH-1:0]     S_AXI4_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI4_ARADDR,
    input  logic [7:0]              S_AXI4_ARLEN,
    input  logic [2:0]              S_AXI4_ARSIZE,
    input  logic [1:0]              S_AXI4_ARBURST,
    input  logic                    S_AXI4_ARLOCK,
    input  logic [3:0]              S_AXI4_ARCACHE,
    input  logic [2:0]              S_AXI4_ARPROT,
    input  logic                    S_AXI4_ARVALID,
    output logic                    S_AXI4_ARREADY,
    output logic [ID_WIDTH-1:0]     S_AXI4_RID,
    output logic [DATA_WIDTH-1:0]   S_AXI4_RDATA,
    output logic [1:0]              S_AXI4_RRESP,
    output logic                    S_AXI4_RLAST,
    output logic                    S_AXI4_RVALID,
    input  logic                    S_AXI4_RREADY,
    output logic [ADDR_WIDTH-1:0]   biu_waddr,
    output logic                    biu_wenable,
    output logic [DATA_WIDTH-1:0]   biu_wdata,
    output logic [DATA_WIDTH/8-1:0] biu_wben,
    input  logic                    biu_waccept,
    input  logic                    biu_werror,
    output logic [ADDR_WIDTH-1:0]   biu_raddr,
    output logic                    biu_renable,
    input  logic [DATA_WIDTH-1:0]   biu_rdata,
    input  logic                    biu_raccept,
    input  logic                    biu_rerror
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int MAX_SIZE   = $clog2(STRB_WIDTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] nxt;
        incr = ADDR_WIDTH'(1) << size;
        nxt  = addr + incr;
        case (burst)
            BURST_FIXED: nxt = addr;
`ifdef VXE_AXI4SLV_BIU_WRAP_EN
            BURST_WRAP: begin
                logic [ADDR_WIDTH-1:0] mask;
                mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
                nxt  = (addr & ~mask) | ((addr + incr) & mask);
            end
`else
            BURST_WRAP: begin
                logic unused_len;
                unused_len = ^len;
                nxt = addr;
            end
`endif
            default: nxt = addr + incr;
        endcase
        return nxt;
    endfunction

    // Bursts that must complete internally with SLVERR and never touch the BIU.
    function automatic logic burst_bad(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        logic bad;
        bad = (size > 3'(MAX_SIZE));
`ifdef VXE_AXI4SLV_BIU_WRAP_EN
        if (burst == BURST_WRAP &&
            !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            bad = 1'b1;
`else
        if (burst == BURST_WRAP)
            bad = 1'b1;
        if (len == 8'd0 && size == 3'd0)
            bad = bad;
`endif
        return bad;
    endfunction

    logic unused_ok;
    assign unused_ok = ^{S_AXI4_AWCACHE, S_AXI4_AWPROT, S_AXI4_ARCACHE, S_AXI4_ARPROT};

    // ---------------- write path ----------------
    wr_state_t               wr_state, wr_next;
    logic [ID_WIDTH-1:0]     wr_id;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [7:0]              wr_len, wr_cnt;
    logic [2:0]              wr_size;
    logic [1:0]              wr_burst;
    logic                    wr_lock, wr_err, wr_bad;
    logic                    wbuf_valid, wbuf_last;
    logic [DATA_WIDTH-1:0]   wbuf_data;
    logic [STRB_WIDTH-1:0]   wbuf_strb;
    logic                    wr_aw_hs, wr_w_hs, wr_beat_done;

    always_ff @(posedge S_AXI4_ACLK or negedge S_AXI4_ARESETn) begin
        if (!S_AXI4_ARESETn) wr_state <= W_IDLE;
        else                 wr_state <= wr_next;
    end

    always_comb begin
        wr_next        = wr_state;
        S_AXI4_AWREADY = 1'b0;
        S_AXI4_WREADY  = 1'b0;
        S_AXI4_BVALID  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                S_AXI4_AWREADY = 1'b1;
                if (S_AXI4_AWVALID) wr_next = W_DATA;
            end
            W_DATA: begin
                S_AXI4_WREADY = ~wbuf_valid;
                if (wr_beat_done && wr_cnt == 8'd0) wr_next = W_RESP;
            end
            W_RESP: begin
                S_AXI4_BVALID = 1'b1;
                if (S_AXI4_BREADY) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    assign wr_aw_hs     = S_AXI4_AWREADY & S_AXI4_AWVALID;
    assign wr_w_hs      = S_AXI4_WREADY & S_AXI4_WVALID;
    assign wr_beat_done = (wr_state == W_DATA) & wbuf_valid & (wr_bad | biu_waccept);

    assign biu_wenable  = wbuf_valid & ~wr_bad;
    assign biu_waddr    = wr_addr;
    assign biu_wdata    = wbuf_data;
    assign biu_wben     = wbuf_strb;
    assign S_AXI4_BID   = wr_id;
    assign S_AXI4_BRESP = wr_err ? RESP_SLVERR : (wr_lock ? RESP_EXOKAY : RESP_OKAY);

    always_ff @(posedge S_AXI4_ACLK or negedge S_AXI4_ARESETn) begin
        if (!S_AXI4_ARESETn) begin
            wr_id      <= '0;
            wr_addr    <= '0;
            wr_len     <= '0;
            wr_cnt     <= '0;
            wr_size    <= '0;
            wr_burst   <= '0;
            wr_lock    <= 1'b0;
            wr_err     <= 1'b0;
            wr_bad     <= 1'b0;
            wbuf_valid <= 1'b0;
            wbuf_last  <= 1'b0;
            wbuf_data  <= '0;
            wbuf_strb  <= '0;
        end else begin
            if (wr_aw_hs) begin
                wr_id    <= S_AXI4_AWID;
                wr_addr  <= S_AXI4_AWADDR;
                wr_len   <= S_AXI4_AWLEN;
                wr_cnt   <= S_AXI4_AWLEN;
                wr_size  <= S_AXI4_AWSIZE;
                wr_burst <= S_AXI4_AWBURST;
                wr_lock  <= S_AXI4_AWLOCK;
                wr_err   <= (S_AXI4_AWBURST == BURST_RSVD);
                wr_bad   <= burst_bad(S_AXI4_AWLEN, S_AXI4_AWSIZE, S_AXI4_AWBURST);
            end
            if (wr_w_hs) begin
                wbuf_valid <= 1'b1;
                wbuf_data  <= S_AXI4_WDATA;
                wbuf_strb  <= S_AXI4_WSTRB;
                wbuf_last  <= S_AXI4_WLAST;
            end else if (wr_beat_done) begin
                wbuf_valid <= 1'b0;
                // A WLAST that disagrees with the beat count poisons the whole burst.
                wr_err <= wr_err | wr_bad | biu_werror | (wbuf_last != (wr_cnt == 8'd0));
                if (wr_cnt != 8'd0) begin
                    wr_addr <= next_addr(wr_addr, wr_len, wr_size, wr_burst);
                    wr_cnt  <= wr_cnt - 8'd1;
                end
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_t               rd_state, rd_next;
    logic [ID_WIDTH-1:0]     rd_id, rid_q;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [7:0]              rd_len, rd_cnt;
    logic [2:0]              rd_size;
    logic [1:0]              rd_burst, rresp_q;
    logic                    rd_lock, rd_rsvd, rd_bad, rd_issued_last;
    logic                    rvalid_q, rlast_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rd_ar_hs, rd_req, rd_beat_done;

    always_ff @(posedge S_AXI4_ACLK or negedge S_AXI4_ARESETn) begin
        if (!S_AXI4_ARESETn) rd_state <= R_IDLE;
        else                 rd_state <= rd_next;
    end

    always_comb begin
        rd_next        = rd_state;
        S_AXI4_ARREADY = 1'b0;
        case (rd_state)
            R_IDLE: begin
                S_AXI4_ARREADY = 1'b1;
                if (S_AXI4_ARVALID) rd_next = R_DATA;
            end
            R_DATA: begin
                if (rvalid_q && S_AXI4_RREADY && rlast_q) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // The output slot frees up in the same cycle RREADY drains it, sustaining one beat per cycle.
    assign rd_ar_hs     = S_AXI4_ARREADY & S_AXI4_ARVALID;
    assign rd_req       = (rd_state == R_DATA) & ~rd_issued_last & (~rvalid_q | S_AXI4_RREADY);
    assign rd_beat_done = rd_req & (rd_bad | biu_raccept);

    assign biu_renable   = rd_req & ~rd_bad;
    assign biu_raddr     = rd_addr;
    assign S_AXI4_RID    = rid_q;
    assign S_AXI4_RDATA  = rdata_q;
    assign S_AXI4_RRESP  = rresp_q;
    assign S_AXI4_RLAST  = rlast_q;
    assign S_AXI4_RVALID = rvalid_q;

    always_ff @(posedge S_AXI4_ACLK or negedge S_AXI4_ARESETn) begin
        if (!S_AXI4_ARESETn) begin
            rd_id          <= '0;
            rid_q          <= '0;
            rd_addr        <= '0;
            rd_len         <= '0;
            rd_cnt         <= '0;
            rd_size        <= '0;
            rd_burst       <= '0;
            rresp_q        <= '0;
            rd_lock        <= 1'b0;
            rd_rsvd        <= 1'b0;
            rd_bad         <= 1'b0;
            rd_issued_last <= 1'b0;
            rvalid_q       <= 1'b0;
            rlast_q        <= 1'b0;
            rdata_q        <= '0;
        end else begin
            if (rd_ar_hs) begin
                rd_id          <= S_AXI4_ARID;
                rd_addr        <= S_AXI4_ARADDR;
                rd_len         <= S_AXI4_ARLEN;
                rd_cnt         <= S_AXI4_ARLEN;
                rd_size        <= S_AXI4_ARSIZE;
                rd_burst       <= S_AXI4_ARBURST;
                rd_lock        <= S_AXI4_ARLOCK;
                rd_rsvd        <= (S_AXI4_ARBURST == BURST_RSVD);
                rd_bad         <= burst_bad(S_AXI4_ARLEN, S_AXI4_ARSIZE, S_AXI4_ARBURST);
                rd_issued_last <= 1'b0;
            end
            if (rd_beat_done) begin
                rvalid_q <= 1'b1;
                rlast_q  <= (rd_cnt == 8'd0);
                rid_q    <= rd_id;
                rdata_q  <= rd_bad ? '0 : biu_rdata;
                rresp_q  <= (rd_bad | rd_rsvd | biu_rerror) ? RESP_SLVERR
                          : (rd_lock ? RESP_EXOKAY : RESP_OKAY);
                rd_addr  <= next_addr(rd_addr, rd_len, rd_size, rd_burst);
                if (rd_cnt == 8'd0) rd_issued_last <= 1'b1;
                else                rd_cnt         <= rd_cnt - 8'd1;
            end else if (rvalid_q && S_AXI4_RREADY) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vxe_axi4slv_burst_biu.sv
`default_nettype none
`timescale 1ns/1ps
// tb_vxe_axi4slv_burst_biu: directed bench for the AXI4 burst BIU with a zero-wait BIU model.
module tb_vxe_axi4slv_burst_biu;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize, awprot, arprot;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awlock, arlock, awvalid, arvalid, awready, arready;
    logic [3:0]    awcache, arcache;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic          wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
    logic [AW-1:0] biu_waddr, biu_raddr;
    logic          biu_wenable, biu_renable;
    logic [DW-1:0] biu_wdata, biu_rdata;
    logic [3:0]    biu_wben;
    logic          biu_waccept, biu_werror, biu_raccept, biu_rerror;
    logic [AW-1:0] werr_addr;

    assign biu_werror = (biu_waddr == werr_addr);
    assign biu_rdata  = biu_raddr ^ 32'hA5A5_0000;

    vxe_axi4slv_burst_biu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .S_AXI4_ACLK(clk), .S_AXI4_ARESETn(rstn),
        .S_AXI4_AWID(awid), .S_AXI4_AWADDR(awaddr), .S_AXI4_AWLEN(awlen), .S_AXI4_AWSIZE(awsize),
        .S_AXI4_AWBURST(awburst), .S_AXI4_AWLOCK(awlock), .S_AXI4_AWCACHE(awcache),
        .S_AXI4_AWPROT(awprot), .S_AXI4_AWVALID(awvalid), .S_AXI4_AWREADY(awready),
        .S_AXI4_WDATA(wdata), .S_AXI4_WSTRB(wstrb), .S_AXI4_WLAST(wlast),
        .S_AXI4_WVALID(wvalid), .S_AXI4_WREADY(wready),
        .S_AXI4_BID(bid), .S_AXI4_BRESP(bresp), .S_AXI4_BVALID(bvalid), .S_AXI4_BREADY(bready),
        .S_AXI4_ARID(arid), .S_AXI4_ARADDR(araddr), .S_AXI4_ARLEN(arlen), .S_AXI4_ARSIZE(arsize),
        .S_AXI4_ARBURST(arburst), .S_AXI4_ARLOCK(arlock), .S_AXI4_ARCACHE(arcache),
        .S_AXI4_ARPROT(arprot), .S_AXI4_ARVALID(arvalid), .S_AXI4_ARREADY(arready),
        .S_AXI4_RID(rid), .S_AXI4_RDATA(rdata), .S_AXI4_RRESP(rresp), .S_AXI4_RLAST(rlast),
        .S_AXI4_RVALID(rvalid), .S_AXI4_RREADY(rready),
        .biu_waddr(biu_waddr), .biu_wenable(biu_wenable), .biu_wdata(biu_wdata),
        .biu_wben(biu_wben), .biu_waccept(biu_waccept), .biu_werror(biu_werror),
        .biu_raddr(biu_raddr), .biu_renable(biu_renable), .biu_rdata(biu_rdata),
        .biu_raccept(biu_raccept), .biu_rerror(biu_rerror)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction logs, sampled on the falling edge ahead of the edge that completes them.
    int wn = 0, rn = 0, bn = 0, rbn = 0;
    logic [AW-1:0] waddr_log [64];
    logic [DW-1:0] wdata_log [64];
    logic [AW-1:0] raddr_log [64];
    logic [DW-1:0] rdata_log [64];
    logic [1:0]    rresp_log [64];
    logic          rlast_log [64];
    logic [IW-1:0] rid_log   [64];
    logic [1:0]    bresp_log [64];
    logic [IW-1:0] bid_log   [64];

    always @(negedge clk) begin
        if (biu_wenable && biu_waccept && wn < 64) begin
            waddr_log[wn] = biu_waddr; wdata_log[wn] = biu_wdata; wn++;
        end
        if (biu_renable && biu_raccept && rn < 64) begin
            raddr_log[rn] = biu_raddr; rn++;
        end
        if (bvalid && bready && bn < 64) begin
            bresp_log[bn] = bresp; bid_log[bn] = bid; bn++;
        end
        if (rvalid && rready && rbn < 64) begin
            rdata_log[rbn] = rdata; rresp_log[rbn] = rresp;
            rlast_log[rbn] = rlast; rid_log[rbn] = rid; rbn++;
        end
    end

    task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu, input logic lk,
                            input int nbeats, input int last_at);
        int t;
        int target;
        target = bn + 1;
        awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awlock = lk; awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!awready && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata = 32'hD000_0000 + i; wstrb = 4'hF; wlast = (i == last_at); wvalid = 1'b1;
            @(negedge clk);
            while (!wready && t < 100) begin @(negedge clk); t++; end
            @(posedge clk); #1;
            wvalid = 1'b0;
        end
        wlast = 1'b0;
        while (bn < target && t < 200) begin @(posedge clk); #1; t++; end
        chk("wr_timeout", (t >= 200), 0);
    endtask

    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu, input logic lk, input bit tog);
        int t;
        int target;
        target = rbn + int'(len) + 1;
        arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arlock = lk; arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        while (rbn < target && t < 200) begin
            if (tog) rready = ~rready;
            @(posedge clk); #1;
            t++;
        end
        rready = 1'b1;
        chk("rd_timeout", (t >= 200), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, b0, w0, n0, t;
`ifdef VXE_AXI4SLV_BIU_WRAP_EN
        logic [AW-1:0] wrap_exp [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
`endif
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0;
        awcache = '0; awprot = '0; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = 1'b0;
        arcache = '0; arprot = '0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        biu_waccept = 1'b1; biu_raccept = 1'b1; biu_rerror = 1'b0;
        werr_addr = 32'hFFFF_FFFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", awready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_payload", {bresp, rresp, bid, rid, rdata}, 0);
        chk("rst_biu_en", {biu_wenable, biu_renable}, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // single INCR write
        do_write(8'h11, 32'h100, 8'd0, 3'd2, 2'b01, 1'b0, 1, 0);
        chk("t1_wbeats", wn, 1);
        chk("t1_waddr", waddr_log[0], 32'h100);
        chk("t1_wdata", wdata_log[0], 32'hD000_0000);
        chk("t1_bresp", bresp_log[0], 2'b00);
        chk("t1_bid", bid_log[0], 8'h11);

        // INCR read burst, RREADY held high then toggled
        for (int pass = 0; pass < 2; pass++) begin
            r0 = rn; b0 = rbn;
            do_read(8'h22 + 8'(pass), 32'h200, 8'd3, 3'd2, 2'b01, 1'b0, pass == 1);
            repeat (4) @(posedge clk);
            #1;
            chk("t2_rbeats", rbn - b0, 4);
            chk("t2_biu_reads", rn - r0, 4);
            for (int i = 0; i < 4; i++) begin
                chk("t2_raddr", raddr_log[r0 + i], 32'h200 + 32'(4 * i));
                chk("t2_rdata", rdata_log[b0 + i], (32'h200 + 32'(4 * i)) ^ 32'hA5A5_0000);
                chk("t2_rlast", rlast_log[b0 + i], (i == 3));
                chk("t2_rresp", rresp_log[b0 + i], 2'b00);
                chk("t2_rid", rid_log[b0 + i], 8'h22 + 8'(pass));
            end
        end

        // WRAP read
        r0 = rn; b0 = rbn;
        do_read(8'h2A, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_rbeats", rbn - b0, 4);
`ifdef VXE_AXI4SLV_BIU_WRAP_EN
        chk("t3_biu_reads", rn - r0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_raddr", raddr_log[r0 + i], wrap_exp[i]);
            chk("t3_rresp", rresp_log[b0 + i], 2'b00);
            chk("t3_rlast", rlast_log[b0 + i], (i == 3));
        end
`else
        chk("t3_biu_reads", rn - r0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_rresp", rresp_log[b0 + i], 2'b10);
            chk("t3_rdata", rdata_log[b0 + i], 32'h0);
            chk("t3_rlast", rlast_log[b0 + i], (i == 3));
        end
`endif

        // write error merge: BIU error on the third beat only
        w0 = wn; n0 = bn;
        werr_addr = 32'h708;
        do_write(8'h33, 32'h700, 8'd2, 3'd2, 2'b01, 1'b0, 3, 2);
        werr_addr = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_wbeats", wn - w0, 3);
        chk("t4_bcount", bn - n0, 1);
        chk("t4_waddr2", waddr_log[w0 + 2], 32'h708);
        chk("t4_bresp", bresp_log[n0], 2'b10);
        chk("t4_bid", bid_log[n0], 8'h33);

        // early WLAST on the second beat
        w0 = wn; n0 = bn;
        do_write(8'h34, 32'h700, 8'd2, 3'd2, 2'b01, 1'b0, 3, 1);
        chk("t5_wbeats", wn - w0, 3);
        chk("t5_bresp", bresp_log[n0], 2'b10);

        // exclusive FIXED write
        w0 = wn; n0 = bn;
        do_write(8'h35, 32'h300, 8'd1, 3'd2, 2'b00, 1'b1, 2, 1);
        chk("t6_wbeats", wn - w0, 2);
        chk("t6_waddr0", waddr_log[w0], 32'h300);
        chk("t6_waddr1", waddr_log[w0 + 1], 32'h300);
        chk("t6_wdata1", wdata_log[w0 + 1], 32'hD000_0001);
        chk("t6_bresp", bresp_log[n0], 2'b01);

        // oversize ARSIZE on a 32-bit bus
        r0 = rn; b0 = rbn;
        do_read(8'h44, 32'h400, 8'd0, 3'd3, 2'b01, 1'b0, 1'b0);
        chk("t7_biu_reads", rn - r0, 0);
        chk("t7_rresp", rresp_log[b0], 2'b10);
        chk("t7_rdata", rdata_log[b0], 32'h0);
        chk("t7_rlast", rlast_log[b0], 1'b1);

        // reset in the middle of a LEN=7 read
        b0 = rbn;
        arid = 8'h55; araddr = 32'h500; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
        arlock = 1'b0; arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        while (rbn < b0 + 2 && t < 100) begin @(posedge clk); #1; t++; end
        chk("t8_progress", rbn - b0, 2);
        rstn = 1'b0;
        #1;
        chk("t8_rvalid", rvalid, 0);
        chk("t8_arready", arready, 1);
        chk("t8_awready", awready, 1);
        chk("t8_renable", biu_renable, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        b0 = rbn;
        do_read(8'h66, 32'h600, 8'd0, 3'd2, 2'b01, 1'b0, 1'b0);
        chk("t8_after_rresp", rresp_log[b0], 2'b00);
        chk("t8_after_rdata", rdata_log[b0], 32'h600 ^ 32'hA5A5_0000);
        chk("t8_after_rid", rid_log[b0], 8'h66);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
